mem_axi_arbiter: RTL

//  Shares the single AXI4 memory port between two masters: s0 = pardcore cached memory traffic,
//  s1 = DMA/front-bus traffic. Sits between the core/DMA side and addr_mapper on the AXI_MEM path.

---
 rtl/mem_axi_arbiter_pkg.sv | 28 ++
 rtl/mem_axi_arbiter_if.sv | 56 +++++
 rtl/mem_axi_arbiter_req_stage.sv | 58 +++++
 rtl/mem_axi_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_axi_arbiter_pkg.sv
// Shared types for the two-master AXI4 memory arbiter: port tags and the
// AR/AW request payload carried through the registered request stages.
package mem_axi_arb_pkg;

  typedef logic port_t;
  localparam port_t S0 = 1'b0;
  localparam port_t S1 = 1'b1;

  localparam int AXI_ADDR_W = 64;
  localparam int AXI_ID_W   = 1;

  function automatic int mid_w(input int id_w);
    return id_w + 1;
  endfunction

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic                  lock;
    logic [3:0]            qos;
  } ax_req_t;

endpackage

// File: rtl/mem_axi_arbiter_if.sv
// AXI4 bundle (AW/W/B/AR/R) with master and slave views; the ID width is set
// per instance so the memory side can carry the extra source-port bit.
interface mem_axi_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1
);
  logic              awvalid, awready, awlock;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize, awprot;
  logic [1:0]        awburst;
  logic [3:0]        awcache, awqos;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic              arvalid, arready, arlock;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst;
  logic [3:0]        arcache, arqos;

  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arqos,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arqos,
    output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/mem_axi_arbiter_req_stage.sv
// Round-robin arbiter feeding a 1-entry registered request stage; used for AR and AW.
// o_push pulses on the slave-side handshake with the accepted port in o_push_port.
module axi_arb_req_stage
  import mem_axi_arb_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  ax_req_t i_req0,
  input  logic    i_valid0,
  output logic    o_ready0,
  input  ax_req_t i_req1,
  input  logic    i_valid1,
  output logic    o_ready1,
  input  logic    i_block,
  output ax_req_t o_req,
  output port_t   o_port,
  output logic    o_valid,
  input  logic    i_ready,
  output logic    o_push,
  output port_t   o_push_port
);
  port_t   r_last;
  port_t   r_port;
  ax_req_t r_req;
  logic    r_valid;
  logic    w_load_ok;
  logic    w_fav0;

  // A port's ready depends only on the other port's valid, never its own.
  always_comb begin
    w_load_ok   = !i_rst && !i_block && (!r_valid || i_ready);
    w_fav0      = (r_last == S1);
    o_ready0    = w_load_ok && (w_fav0 || !i_valid1);
    o_ready1    = w_load_ok && (!w_fav0 || !i_valid0);
    o_push      = (i_valid0 && o_ready0) || (i_valid1 && o_ready1);
    o_push_port = (i_valid1 && o_ready1) ? S1 : S0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last  <= S1;
      r_port  <= S0;
      r_req   <= '0;
      r_valid <= 1'b0;
    end else if (o_push) begin
      r_last  <= o_push_port;
      r_port  <= o_push_port;
      r_req   <= (o_push_port == S1) ? i_req1 : i_req0;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_req   = r_req;
  assign o_port  = r_port;
  assign o_valid = r_valid;
endmodule

// File: rtl/mem_axi_arbiter.sv
// Shares one AXI4 memory port between pardcore (s0) and DMA (s1). The ID msb on the
// memory side tags the source; W bursts follow AW grant order via a small port FIFO.
module mem_axi_arbiter
  import mem_axi_arb_pkg::*;
#(
  parameter int ADDR_W     = AXI_ADDR_W,
  parameter int DATA_W     = 64,
  parameter int ID_W       = AXI_ID_W,
  parameter int WORD_DEPTH = 4
) (
  input  logic      uncoreclk,
  input  logic      uncorerst,
  mem_axi_if.slave  s0_axi,
  mem_axi_if.slave  s1_axi,
  mem_axi_if.master m_axi
);
  localparam int MID_W = mid_w(ID_W);
  localparam int PTR_W = $clog2(WORD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ax_req_t w_ar0, w_ar1, w_ar_out, w_aw0, w_aw1, w_aw_out;
  port_t   w_ar_port, w_aw_port, w_aw_push_port, w_head, w_ar_hs_port_unused;
  logic    w_ar_valid, w_aw_valid, w_aw_push, w_ar_hs_unused;
  logic    w_full, w_empty, w_pop, w_wvalid, w_wlast;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;

  port_t            r_fifo [WORD_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  assign w_ar0 = '{addr: s0_axi.araddr, id: s0_axi.arid, len: s0_axi.arlen, size: s0_axi.arsize,
                   burst: s0_axi.arburst, cache: s0_axi.arcache, prot: s0_axi.arprot,
                   lock: s0_axi.arlock, qos: s0_axi.arqos};
  assign w_ar1 = '{addr: s1_axi.araddr, id: s1_axi.arid, len: s1_axi.arlen, size: s1_axi.arsize,
                   burst: s1_axi.arburst, cache: s1_axi.arcache, prot: s1_axi.arprot,
                   lock: s1_axi.arlock, qos: s1_axi.arqos};
  assign w_aw0 = '{addr: s0_axi.awaddr, id: s0_axi.awid, len: s0_axi.awlen, size: s0_axi.awsize,
                   burst: s0_axi.awburst, cache: s0_axi.awcache, prot: s0_axi.awprot,
                   lock: s0_axi.awlock, qos: s0_axi.awqos};
  assign w_aw1 = '{addr: s1_axi.awaddr, id: s1_axi.awid, len: s1_axi.awlen, size: s1_axi.awsize,
                   burst: s1_axi.awburst, cache: s1_axi.awcache, prot: s1_axi.awprot,
                   lock: s1_axi.awlock, qos: s1_axi.awqos};

  axi_arb_req_stage u_ar (
    .i_clk(uncoreclk), .i_rst(uncorerst),
    .i_req0(w_ar0), .i_valid0(s0_axi.arvalid), .o_ready0(s0_axi.arready),
    .i_req1(w_ar1), .i_valid1(s1_axi.arvalid), .o_ready1(s1_axi.arready),
    .i_block(1'b0),
    .o_req(w_ar_out), .o_port(w_ar_port), .o_valid(w_ar_valid), .i_ready(m_axi.arready),
    .o_push(w_ar_hs_unused), .o_push_port(w_ar_hs_port_unused)
  );

  // A full order FIFO stalls AW outright, even if a pop lands the same cycle.
  axi_arb_req_stage u_aw (
    .i_clk(uncoreclk), .i_rst(uncorerst),
    .i_req0(w_aw0), .i_valid0(s0_axi.awvalid), .o_ready0(s0_axi.awready),
    .i_req1(w_aw1), .i_valid1(s1_axi.awvalid), .o_ready1(s1_axi.awready),
    .i_block(w_full),
    .o_req(w_aw_out), .o_port(w_aw_port), .o_valid(w_aw_valid), .i_ready(m_axi.awready),
    .o_push(w_aw_push), .o_push_port(w_aw_push_port)
  );

  assign m_axi.arvalid = w_ar_valid;
  assign m_axi.arid    = MID_W'({w_ar_port, w_ar_out.id});
  assign m_axi.araddr  = ADDR_W'(w_ar_out.addr);
  assign m_axi.arlen   = w_ar_out.len;
  assign m_axi.arsize  = w_ar_out.size;
  assign m_axi.arburst = w_ar_out.burst;
  assign m_axi.arcache = w_ar_out.cache;
  assign m_axi.arprot  = w_ar_out.prot;
  assign m_axi.arlock  = w_ar_out.lock;
  assign m_axi.arqos   = w_ar_out.qos;

  assign m_axi.awvalid = w_aw_valid;
  assign m_axi.awid    = MID_W'({w_aw_port, w_aw_out.id});
  assign m_axi.awaddr  = ADDR_W'(w_aw_out.addr);
  assign m_axi.awlen   = w_aw_out.len;
  assign m_axi.awsize  = w_aw_out.size;
  assign m_axi.awburst = w_aw_out.burst;
  assign m_axi.awcache = w_aw_out.cache;
  assign m_axi.awprot  = w_aw_out.prot;
  assign m_axi.awlock  = w_aw_out.lock;
  assign m_axi.awqos   = w_aw_out.qos;

  assign w_full  = (r_count == CNT_W'(WORD_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_head];
  assign w_pop   = w_wvalid && m_axi.wready && w_wlast;

  always_ff @(posedge uncoreclk or posedge uncorerst) begin
    if (uncorerst) begin
      for (int i = 0; i < WORD_DEPTH; i++) r_fifo[i] <= S0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_aw_push) begin
        r_fifo[r_tail] <= w_aw_push_port;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_aw_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_wvalid      = 1'b0;
    w_wdata       = s0_axi.wdata;
    w_wstrb       = s0_axi.wstrb;
    w_wlast       = s0_axi.wlast;
    s0_axi.wready = 1'b0;
    s1_axi.wready = 1'b0;
    if (!w_empty) begin
      if (w_head == S1) begin
        w_wvalid      = s1_axi.wvalid;
        w_wdata       = s1_axi.wdata;
        w_wstrb       = s1_axi.wstrb;
        w_wlast       = s1_axi.wlast;
        s1_axi.wready = m_axi.wready;
      end else begin
        w_wvalid      = s0_axi.wvalid;
        s0_axi.wready = m_axi.wready;
      end
    end
  end

  assign m_axi.wvalid = w_wvalid;
  assign m_axi.wdata  = w_wdata;
  assign m_axi.wstrb  = w_wstrb;
  assign m_axi.wlast  = w_wlast;

  // Responses steer on the source tag carried in the ID msb.
  assign s0_axi.rvalid = m_axi.rvalid && (m_axi.rid[ID_W] == S0);
  assign s1_axi.rvalid = m_axi.rvalid && (m_axi.rid[ID_W] == S1);
  assign m_axi.rready  = (m_axi.rid[ID_W] == S1) ? s1_axi.rready : s0_axi.rready;
  assign s0_axi.rid    = m_axi.rid[ID_W-1:0];
  assign s1_axi.rid    = m_axi.rid[ID_W-1:0];
  assign s0_axi.rdata  = m_axi.rdata;
  assign s1_axi.rdata  = m_axi.rdata;
  assign s0_axi.rresp  = m_axi.rresp;
  assign s1_axi.rresp  = m_axi.rresp;
  assign s0_axi.rlast  = m_axi.rlast;
  assign s1_axi.rlast  = m_axi.rlast;

  assign s0_axi.bvalid = m_axi.bvalid && (m_axi.bid[ID_W] == S0);
  assign s1_axi.bvalid = m_axi.bvalid && (m_axi.bid[ID_W] == S1);
  assign m_axi.bready  = (m_axi.bid[ID_W] == S1) ? s1_axi.bready : s0_axi.bready;
  assign s0_axi.bid    = m_axi.bid[ID_W-1:0];
  assign s1_axi.bid    = m_axi.bid[ID_W-1:0];
  assign s0_axi.bresp  = m_axi.bresp;
  assign s1_axi.bresp  = m_axi.bresp;
endmodule
